// File: rtl/cdb_pkg.sv
// Shared widths and types for the Common Data Bus arbiter slice.
package cdb_pkg;

    localparam int CDB_NUM_FU = 4;
    localparam int TAG_W      = 6;
    localparam int DATA_W     = 32;
    localparam int SRC_W      = $clog2(CDB_NUM_FU);

    typedef logic [SRC_W-1:0] rank_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              exc;
        rank_t             src;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result ports plus the registered CDB broadcast.
interface cdb_arbiter_if import cdb_pkg::*; #(
    parameter int NUM_FU = CDB_NUM_FU
);

    logic [NUM_FU-1:0]        i_fu_valid;
    logic [NUM_FU*TAG_W-1:0]  i_fu_tag;
    logic [NUM_FU*DATA_W-1:0] i_fu_data;
    logic [NUM_FU-1:0]        i_fu_exc;
    logic [NUM_FU-1:0]        o_fu_ready;
    logic                     i_cdb_stall;
    logic                     i_flush;
    logic                     o_cdb_valid;
    logic [TAG_W-1:0]         o_cdb_tag;
    logic [DATA_W-1:0]        o_cdb_data;
    logic                     o_cdb_exc;
    rank_t                    o_cdb_src;
    logic                     o_starve_err;

    modport master (
        output i_fu_valid, i_fu_tag, i_fu_data, i_fu_exc, i_cdb_stall, i_flush,
        input  o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_exc,
               o_cdb_src, o_starve_err
    );

    modport slave (
        input  i_fu_valid, i_fu_tag, i_fu_data, i_fu_exc, i_cdb_stall, i_flush,
        output o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_exc,
               o_cdb_src, o_starve_err
    );

endinterface

// File: rtl/cdb_lrg_rank.sv
// Least-recently-granted rank table: picks the valid requester with the lowest
// rank and moves the winner to the back of the order on each transfer.
module cdb_lrg_rank import cdb_pkg::*; #(
    parameter int NUM_FU = CDB_NUM_FU
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_FU-1:0] req,
    input  logic              xfer,
    output logic [NUM_FU-1:0] win_oh,
    output rank_t             win_idx
);

    rank_t rank [NUM_FU];
    rank_t best;
    logic  found;

    always_comb begin
        found   = 1'b0;
        best    = '0;
        win_idx = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (req[i] && (!found || rank[i] < best)) begin
                found   = 1'b1;
                best    = rank[i];
                win_idx = rank_t'(i);
            end
        end
        win_oh = found ? (NUM_FU'(1) << win_idx) : '0;
    end

    // Ranks stay a permutation: everyone behind the winner moves up one slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_FU; i++) begin
                rank[i] <= rank_t'(i);
            end
        end else if (xfer) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (win_oh[i]) begin
                    rank[i] <= rank_t'(NUM_FU - 1);
                end else if (rank[i] > rank[win_idx]) begin
                    rank[i] <= rank[i] - rank_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: gates the LRG winner with stall/flush, registers the broadcast
// and watches for requesters that wait too long.
module cdb_arbiter import cdb_pkg::*; #(
    parameter int NUM_FU = CDB_NUM_FU
) (
    input logic          clk,
    input logic          rstn,
    cdb_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(NUM_FU + 1);

    logic [NUM_FU-1:0] win_oh;
    logic [NUM_FU-1:0] ready;
    rank_t             win_idx;
    logic              grant_en;
    logic              xfer;
    cdb_pkt_t          cdb_q;
    logic [CNT_W-1:0]  wait_cnt [NUM_FU];
    logic              starve_hit;
    logic              starve_q;

    assign grant_en = !bus.i_cdb_stall && !bus.i_flush && (|bus.i_fu_valid);
    assign ready    = grant_en ? win_oh : '0;
    assign xfer     = |(bus.i_fu_valid & ready);

    cdb_lrg_rank #(.NUM_FU(NUM_FU)) u_rank (
        .clk     (clk),
        .rstn    (rstn),
        .req     (bus.i_fu_valid),
        .xfer    (xfer),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    // Payload holds its last value between pulses; only valid drops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cdb_q <= '0;
        end else if (xfer) begin
            cdb_q.valid <= 1'b1;
            cdb_q.tag   <= bus.i_fu_tag[win_idx*TAG_W +: TAG_W];
            cdb_q.data  <= bus.i_fu_data[win_idx*DATA_W +: DATA_W];
            cdb_q.exc   <= bus.i_fu_exc[win_idx];
            cdb_q.src   <= win_idx;
        end else begin
            cdb_q.valid <= 1'b0;
        end
    end

    always_comb begin
        starve_hit = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (wait_cnt[i] == CNT_W'(NUM_FU)) begin
                starve_hit = 1'b1;
            end
        end
    end

    // Stall freezes the counters; flush discards all waiting history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wait_cnt[i] <= '0;
            end
            starve_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (bus.i_flush || !bus.i_fu_valid[i] || ready[i]) begin
                    wait_cnt[i] <= '0;
                end else if (!bus.i_cdb_stall && wait_cnt[i] != CNT_W'(NUM_FU)) begin
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                end
            end
            starve_q <= starve_q | starve_hit;
        end
    end

    assign bus.o_fu_ready   = ready;
    assign bus.o_cdb_valid  = cdb_q.valid;
    assign bus.o_cdb_tag    = cdb_q.tag;
    assign bus.o_cdb_data   = cdb_q.data;
    assign bus.o_cdb_exc    = cdb_q.exc;
    assign bus.o_cdb_src    = cdb_q.src;
    assign bus.o_starve_err = starve_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single Common Data Bus (CDB) among NUM_FU functional-unit result ports in the out-of-order core.
- Selects one valid result per cycle using a least-recently-granted rank order and returns a same-cycle ready handshake to the winner.
- Registers the winner onto the CDB broadcast for the ROB and reservation stations.
- Honours pipeline stall and flush, and carries a starvation watchdog for verification.

Parameters:
- NUM_FU, 4, number of requesting functional units (>=2)
- TAG_W, 6, ROB tag width
- DATA_W, 32, result data width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_fu_valid  in  NUM_FU  per-FU result valid
- i_fu_tag  in  NUM_FU*TAG_W  flattened tags, FU i at [i*TAG_W +: TAG_W]
- i_fu_data  in  NUM_FU*DATA_W  flattened results, same packing
- i_fu_exc  in  NUM_FU  per-FU exception flag
- o_fu_ready  out  NUM_FU  one-hot grant/ready, combinational
- i_cdb_stall  in  1  suppress new grants this cycle
- i_flush  in  1  pipeline flush
- o_cdb_valid  out  1  broadcast valid, one-cycle pulse per transfer
- o_cdb_tag  out  TAG_W  broadcast tag
- o_cdb_data  out  DATA_W  broadcast data
- o_cdb_exc  out  1  broadcast exception flag
- o_cdb_src  out  $clog2(NUM_FU)  index of the granted FU
- o_starve_err  out  1  sticky watchdog error

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low on rstn.
- Reset values: o_cdb_valid=0, o_cdb_tag=0, o_cdb_data=0, o_cdb_exc=0, o_cdb_src=0, o_starve_err=0, rank[i]=i, wait_cnt[i]=0. Reset mid-operation clears all state immediately, including an in-flight broadcast.
- Rank state:
  - rank[i] has width $clog2(NUM_FU). Ranks always form a permutation of 0..NUM_FU-1; 0 is highest priority.
- Grant (combinational):
  - Winner = the valid FU with the lowest rank.
  - o_fu_ready = one-hot winner when !i_cdb_stall && !i_flush && |i_fu_valid; otherwise 0.
  - o_fu_ready is never asserted for an FU whose valid is low.
- Transfer: occurs when i_fu_valid[w] && o_fu_ready[w]. The FU drops or advances its result on the same edge.
- Latency: one cycle. On a transfer edge, the winner's tag/data/exc/index are loaded and o_cdb_valid=1.
- o_cdb_valid: cleared on any edge without a transfer, so back-to-back transfers give back-to-back pulses. Payload registers hold their last value while valid is low.
- Rank update (transfer edges only):
  - Every FU with rank > rank[w] decrements by 1.
  - rank[w] becomes NUM_FU-1.
  - No transfer (idle, stall, flush): ranks unchanged.
- Stall: no grant, no rank change, wait counters hold. An o_cdb_valid already asserted still completes its single cycle.
- Flush: same as stall for grants. The next cycle's o_cdb_valid is 0, and all wait_cnt clear. A broadcast visible during the flush cycle is not retracted; the ROB discards it.
- Simultaneous stall and flush: flush semantics apply.
- Watchdog:
  - wait_cnt[i] increments (saturating at NUM_FU) when i_fu_valid[i] && !o_fu_ready[i] && !i_cdb_stall && !i_flush.
  - wait_cnt[i] clears on transfer of FU i or when i_fu_valid[i]=0.
  - o_starve_err is set and held until reset if any wait_cnt reaches NUM_FU. By construction, a correct design never sets it.
- Requester rule: FUs keep valid, tag, data and exc stable until granted. The arbiter does not register inputs.

Decomposition:
- Package cdb_pkg:
  - parameters TAG_W and DATA_W
  - typedef cdb_pkt_t {valid, tag, data, exc, src}
  - rank_t
- Sub-module cdb_lrg_rank, holding:
  - the rank array and its reset
  - winner selection from i_fu_valid
  - the update on transfer
- The top level contains the handshake gating, the output register, and the watchdog.

Test Plan:
1. After reset, i_fu_valid=4'b1111 held, stall/flush=0 -> o_fu_ready one-hot cycles FU0,1,2,3,0,...; o_cdb_src 0,1,2,3 one cycle later; o_cdb_valid constantly 1.
2. Only FU2 valid, tag=5, data=32'hDEADBEEF, exc=0 -> o_fu_ready=4'b0100 same cycle; next cycle o_cdb_valid=1, tag=5, data=DEADBEEF, src=2; following cycle o_cdb_valid=0.
3. From reset, transfer FU1 alone (ranks become {0,3,1,2}), then all valid -> grant order FU0, FU2, FU3, FU1.
4. i_fu_valid=4'b0011 with i_cdb_stall=1 for 3 cycles -> o_fu_ready=0, o_cdb_valid=0, ranks unchanged; stall released -> FU0 granted, then FU1.
5. i_flush=1 coincident with FU3 valid -> o_fu_ready=0 and next o_cdb_valid=0; with flush low next cycle, FU3 granted.
6. Random valid/stall/flush for 10k cycles plus a rstn pulse while o_cdb_valid=1 -> o_starve_err stays 0, ranks remain a permutation, outputs are 0 immediately on rstn low, and ranks return to {0,1,2,3}.
